// File: rtl/cplx_acc_dump.sv
// cplx_acc_dump
//   Complex accumulate-and-dump stage. Sums N = len+1 consecutive signed
//   W-bit complex samples into ACC_W = W+NMAX_LOG2 bit accumulators. At frame
//   end it applies a round-half-up arithmetic right shift and saturates back
//   to W bits. The result is presented on a single-entry valid/ready output
//   register. If that register is still occupied when a new frame
//   completes, the new result is discarded and the sticky drop flag is set.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   clr                synchronous clear: abort partial frame, clear drop
//   in_valid/in_r/in_i sample stream (never backpressured)
//   len, shift         frame length-1 and scale shift, latched on first sample
//   out_valid/out_ready/out_r/out_i/out_sat  result handshake
//   busy               frame in progress
//   drop               sticky: a completed frame was discarded

// Per-component scaler: round-half-up shift plus saturation to W bits.
module cplx_acc_dump_scale #(
    parameter int W     = 24,
    parameter int ACC_W = 32,
    parameter int SHW   = 4
) (
    input  logic signed [ACC_W-1:0] dump,
    input  logic        [SHW-1:0]   sh,
    output logic        [W-1:0]     q,
    output logic                    sat
);
    localparam int EW = ACC_W + 1;
    // One extra bit so that adding the rounding constant can never wrap.
    localparam logic signed [EW-1:0] MAXV = {{(EW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = ~MAXV;

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;
    logic signed [EW-1:0] t;

    always_comb begin
        ext = {dump[ACC_W-1], dump};
        rnd = '0;
        if (sh != '0)
            rnd = EW'(1) << (sh - SHW'(1));
        t   = (ext + rnd) >>> sh;
        q   = t[W-1:0];
        sat = 1'b0;
        if (t > MAXV) begin
            q   = MAXV[W-1:0];
            sat = 1'b1;
        end else if (t < MINV) begin
            q   = MINV[W-1:0];
            sat = 1'b1;
        end
    end
endmodule

module cplx_acc_dump #(
    parameter  int W         = 24,
    parameter  int NMAX_LOG2 = 8,
    localparam int SHW       = $clog2(NMAX_LOG2 + 1),
    localparam int ACC_W     = W + NMAX_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_r,
    input  logic [W-1:0]         in_i,
    input  logic [NMAX_LOG2-1:0] len,
    input  logic [SHW-1:0]       shift,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_r,
    output logic [W-1:0]         out_i,
    output logic                 out_sat,
    output logic                 busy,
    output logic                 drop
);
    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    state_t state, state_nxt;

    // Component 0 is real, component 1 is imaginary.
    logic [1:0][W-1:0]     smp_in;
    logic [1:0][ACC_W-1:0] samp;
    logic [1:0][ACC_W-1:0] acc;
    logic [1:0][ACC_W-1:0] acc_sum;
    logic [1:0][ACC_W-1:0] dump;
    logic [1:0][W-1:0]     q;
    logic [1:0]            sat;

    logic [NMAX_LOG2-1:0]  len_l;
    logic [NMAX_LOG2-1:0]  count;
    logic [SHW-1:0]        shift_l;
    logic [SHW-1:0]        shift_c;
    logic [SHW-1:0]        dump_sh;
    logic                  dump_v;

    logic                  first;
    logic                  accum;
    logic                  done;

    assign smp_in  = {in_i, in_r};
    assign shift_c = (shift > SHW'(NMAX_LOG2)) ? SHW'(NMAX_LOG2) : shift;
    assign busy    = (state == ACC);

    for (genvar c = 0; c < 2; c++) begin : g_cmp
        assign samp[c]    = {{NMAX_LOG2{smp_in[c][W-1]}}, smp_in[c]};
        assign acc_sum[c] = acc[c] + samp[c];

        cplx_acc_dump_scale #(
            .W     (W),
            .ACC_W (ACC_W),
            .SHW   (SHW)
        ) u_scale (
            .dump (dump[c]),
            .sh   (dump_sh),
            .q    (q[c]),
            .sat  (sat[c])
        );
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        first     = 1'b0;
        accum     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    first = 1'b1;
                    if (len == '0)
                        done = 1'b1;
                    else
                        state_nxt = ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    accum = 1'b1;
                    if (count == len_l) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A sample arriving with clr is discarded along with the frame.
        if (clr) begin
            state_nxt = IDLE;
            first     = 1'b0;
            accum     = 1'b0;
            done      = 1'b0;
        end
    end

    // ---------------- accumulator / dump ----------------
    // The dump carries its own shift so the next frame may latch a new
    // shift while this result is still being scaled.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_l   <= '0;
            shift_l <= '0;
            count   <= '0;
            acc     <= '0;
            dump    <= '0;
            dump_sh <= '0;
            dump_v  <= 1'b0;
        end else if (clr) begin
            count   <= '0;
            acc     <= '0;
            dump_v  <= 1'b0;
        end else begin
            dump_v <= done;
            if (first) begin
                len_l   <= len;
                shift_l <= shift_c;
                count   <= NMAX_LOG2'(1);
                acc     <= samp;
            end else if (accum) begin
                count   <= count + NMAX_LOG2'(1);
                acc     <= acc_sum;
            end
            if (done) begin
                dump    <= first ? samp : acc_sum;
                dump_sh <= first ? shift_c : shift_l;
            end
        end
    end

    // ---------------- output register ----------------
    // A dump pending in the clr cycle is discarded, so it neither loads
    // nor sets drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            out_sat   <= 1'b0;
            drop      <= 1'b0;
        end else begin
            if (dump_v && !clr && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_r     <= q[0];
                out_i     <= q[1];
                out_sat   <= |sat;
            end else if (dump_v && !clr) begin
                drop      <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (clr)
                drop <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cplx_acc_dump.sv
// Testbench for cplx_acc_dump: directed test-plan sequences followed by
// randomized traffic, all checked every cycle against a frame-level model.
module tb_cplx_acc_dump;
    localparam int W    = 24;
    localparam int NMAX = 8;
    localparam int SHW  = 4;

    logic            clk = 1'b0;
    logic            rst, clr, in_valid, out_ready;
    logic [W-1:0]    in_r, in_i;
    logic [NMAX-1:0] len;
    logic [SHW-1:0]  shift;
    logic            out_valid, out_sat, busy, drop;
    logic [W-1:0]    out_r, out_i;

    always #5 clk = ~clk;

    cplx_acc_dump #(.W(W), .NMAX_LOG2(NMAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_r      (in_r),
        .in_i      (in_i),
        .len       (len),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_sat   (out_sat),
        .busy      (busy),
        .drop      (drop)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame state as plain sums; the completed frame waits one cycle
    // (pending) before reaching the output register.
    bit     m_busy, m_pend, m_ov, m_osat, m_drop, m_ps;
    int     m_n, m_len, m_sh;
    longint m_sr, m_si, m_pr, m_pi, m_or, m_oi;

    function automatic longint scale(input longint s, input int sh, output bit sat);
        longint t, hi, lo;
        hi  = (longint'(1) <<< (W-1)) - 1;
        lo  = -(longint'(1) <<< (W-1));
        t   = (sh == 0) ? s : ((s + (longint'(1) <<< (sh-1))) >>> sh);
        sat = 1'b0;
        if (t > hi) begin t = hi; sat = 1'b1; end
        if (t < lo) begin t = lo; sat = 1'b1; end
        return t;
    endfunction

    task automatic model_step();
        bit sr_sat, si_sat;
        if (rst) begin
            m_busy = 0; m_pend = 0; m_ov = 0; m_osat = 0; m_drop = 0;
            m_n = 0; m_or = 0; m_oi = 0;
            return;
        end
        if (m_pend && !clr) begin
            if (!m_ov || out_ready) begin
                m_ov = 1; m_or = m_pr; m_oi = m_pi; m_osat = m_ps;
            end else
                m_drop = 1;
        end else if (m_ov && out_ready)
            m_ov = 0;
        m_pend = 0;
        if (clr) begin
            m_drop = 0; m_busy = 0; m_n = 0;
            return;
        end
        if (in_valid) begin
            if (!m_busy) begin
                m_len = int'(len);
                m_sh  = (int'(shift) > NMAX) ? NMAX : int'(shift);
                m_sr  = longint'($signed(in_r));
                m_si  = longint'($signed(in_i));
                m_n   = 1;
            end else begin
                m_sr += longint'($signed(in_r));
                m_si += longint'($signed(in_i));
                m_n++;
            end
            if (m_n == m_len + 1) begin
                m_busy = 0;
                m_pend = 1;
                m_pr   = scale(m_sr, m_sh, sr_sat);
                m_pi   = scale(m_si, m_sh, si_sat);
                m_ps   = sr_sat | si_sat;
            end else
                m_busy = 1;
        end
    endtask

    // One clock: model consumes the same inputs the DUT sees, then compare.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("out_valid", longint'(out_valid), longint'(m_ov));
        chk("busy", longint'(busy), longint'(m_busy));
        chk("drop", longint'(drop), longint'(m_drop));
        if (m_ov) begin
            chk("out_r", longint'($signed(out_r)), m_or);
            chk("out_i", longint'($signed(out_i)), m_oi);
            chk("out_sat", longint'(out_sat), longint'(m_osat));
        end
    endtask

    task automatic cyc(input bit v, input longint r, input longint i);
        in_valid = v;
        in_r     = W'(r);
        in_i     = W'(i);
        tick();
    endtask

    initial begin
        rst = 1; clr = 0; in_valid = 0; out_ready = 1;
        in_r = '0; in_i = '0; len = '0; shift = '0;
        tick();
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_r", longint'(out_r), 0);
        chk("rst_out_i", longint'(out_i), 0);
        chk("rst_out_sat", longint'(out_sat), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_drop", longint'(drop), 0);
        tick();
        rst = 0;

        // N=4, shift 2: (400,-400) -> (100,-100), out_valid 2 cycles late
        len = 3; shift = 2;
        for (int k = 0; k < 4; k++) cyc(1, 100, -100);
        chk("t1_not_yet", longint'(out_valid), 0);
        cyc(0, 0, 0);
        chk("t1_valid", longint'(out_valid), 1);
        chk("t1_r", longint'($signed(out_r)), 100);
        chk("t1_i", longint'($signed(out_i)), -100);
        chk("t1_sat", longint'(out_sat), 0);
        cyc(0, 0, 0);

        // N=2, shift 1: round half up on both signs
        len = 1; shift = 1;
        cyc(1, 1, -1); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        chk("t2_r", longint'($signed(out_r)), 1);
        chk("t2_i", longint'($signed(out_i)), 0);

        // N=256 full-scale samples saturate
        len = 255; shift = 0;
        for (int k = 0; k < 256; k++) cyc(1, 64'h7FFFFF, -64'sd8388608);
        cyc(0, 0, 0); cyc(0, 0, 0);
        chk("t3_r", longint'($signed(out_r)), 8388607);
        chk("t3_i", longint'($signed(out_i)), -8388608);
        chk("t3_sat", longint'(out_sat), 1);

        // N=1 streaming, then stall to force a drop
        len = 0; shift = 0;
        for (int k = 1; k <= 4; k++) cyc(1, k, -k);
        out_ready = 0;
        cyc(1, 5, -5); cyc(1, 6, -6); cyc(0, 0, 0); cyc(0, 0, 0);
        chk("t4_drop", longint'(drop), 1);
        chk("t4_hold", longint'(out_valid), 1);
        out_ready = 1;
        cyc(0, 0, 0);

        // clr aborts a partial frame and clears drop
        len = 3; shift = 0;
        cyc(1, 7, 7); cyc(1, 7, 7);
        clr = 1; cyc(1, 9, 9); clr = 0;
        for (int k = 0; k < 4; k++) cyc(1, 5, 5);
        out_ready = 0;
        cyc(0, 0, 0); cyc(0, 0, 0);
        chk("t5_r", longint'($signed(out_r)), 20);
        chk("t5_drop", longint'(drop), 0);

        // rst mid-frame while out_valid is held
        cyc(1, 1, 1); cyc(1, 1, 1);
        rst = 1; cyc(0, 0, 0); rst = 0;
        chk("t6_valid", longint'(out_valid), 0);
        chk("t6_r", longint'(out_r), 0);
        chk("t6_i", longint'(out_i), 0);
        chk("t6_busy", longint'(busy), 0);
        out_ready = 1;
        for (int k = 0; k < 4; k++) cyc(1, 3, -2);
        cyc(0, 0, 0); cyc(0, 0, 0);
        chk("t6_sum_r", longint'($signed(out_r)), 12);
        chk("t6_sum_i", longint'($signed(out_i)), -8);

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            rst       = ($urandom_range(0, 499) == 0);
            clr       = ($urandom_range(0, 149) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            shift     = SHW'($urandom_range(0, 15));
            len       = ($urandom_range(0, 3) == 0) ? NMAX'($urandom_range(0, 255))
                                                    : NMAX'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0)
                cyc($urandom_range(0, 9) < 7, longint'($urandom), longint'($urandom));
            else
                cyc($urandom_range(0, 9) < 7, longint'(int'($urandom_range(0, 200)) - 100),
                    longint'(int'($urandom_range(0, 200)) - 100));
        end
        rst = 0; clr = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
